digitub_scanmux: RTL

DIGITUB_SCANMUX -- requirements
Module: digitub_scanmux

---
 rtl/digitub_scanmux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/digitub_scanmux.sv
// Four-digit multiplexed 7-segment scanner: each slot gets a blank phase then a lit
// phase; all slots show data from a snapshot taken once per frame so frames never tear.
module digitub_scanmux #(
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] digout1,
  input  logic [7:0] digout2,
  input  logic [7:0] digout3,
  input  logic [7:0] digout4,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick,
  output logic       dbg_state
);

  localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          capture;

  logic [27:0]   snap_seg, snap_seg_n;
  logic [3:0]    snap_dp, snap_dp_n;

  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  assign dbg_state = state;

  // Phase sequencing; everything freezes while en is low.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    capture = 1'b0;
    if (en) begin
      capture = (state == BLANK) && (idx == 2'd0) && (cnt == '0);
      if (state == BLANK) begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end else begin
        if (cnt == SHOW_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    snap_seg_n = snap_seg;
    snap_dp_n  = snap_dp;
    if (capture) begin
      snap_seg_n = {digout4[6:0], digout3[6:0], digout2[6:0], digout1[6:0]};
      snap_dp_n  = dp_en;
    end
  end

  // Outputs are computed from the next state so they change on the transition edge.
  // The post-capture snapshot is used so a one-cycle blank phase still shows fresh data.
  always_comb begin
    an_n  = 4'b1111;
    seg_n = 7'b1111111;
    dp_n  = 1'b1;
    if (en && (state_n == SHOW)) begin
      dp_n = ~snap_dp_n[idx_n];
      case (idx_n)
        2'd0: begin an_n = 4'b1110; seg_n = snap_seg_n[6:0];   end
        2'd1: begin an_n = 4'b1101; seg_n = snap_seg_n[13:7];  end
        2'd2: begin an_n = 4'b1011; seg_n = snap_seg_n[20:14]; end
        default: begin an_n = 4'b0111; seg_n = snap_seg_n[27:21]; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      idx        <= 2'd0;
      cnt        <= '0;
      snap_seg   <= '1;
      snap_dp    <= 4'b0000;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      snap_seg   <= snap_seg_n;
      snap_dp    <= snap_dp_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_tick <= capture;
    end
  end

endmodule
